// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit that drives the STALL/FLUSH pins of the IF/ID and
// ID/EX inter-stage registers. It handles four hazard sources:
//   - load-use hazards between the load in EX and the instruction in ID
//   - multi-cycle mult/div occupying EX (front end held while it runs)
//   - fetch misses (bubble into IF/ID)
//   - external exception/redirect flushes (highest priority)
//
// Parameters:
//   MD_LATENCY  EX occupancy of a mult/div in cycles (1..15)
//   CNT_W       width of the mult/div countdown register
//
// Ports:
//   CLK          rising-edge clock
//   RESET        asynchronous, active-low reset
//   EXT_FLUSH    exception/redirect flush request for this cycle
//   IF_Ready     fetch stage presents a valid instruction
//   ID_Valid     IF/ID holds a real instruction
//   ID_RS/ID_RT  source registers of the ID instruction
//   ID_UsesRT    ID instruction reads rt
//   ID_MulDiv    ID instruction is mult/multu/div/divu
//   EX_Valid     ID/EX holds a real instruction
//   EX_MemRead   EX instruction is a load
//   EX_Dest      destination register of the EX instruction
//   STALL_IF     hold PC and IF/ID
//   FLUSH_IFID   load a bubble into IF/ID
//   FLUSH_IDEX   load a bubble into ID/EX
//   MD_Busy      a mult/div is still occupying EX
//   Stall_Count  saturating count of cycles with STALL_IF asserted
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EXT_FLUSH,
    input  logic        IF_Ready,
    input  logic        ID_Valid,
    input  logic [4:0]  ID_RS,
    input  logic [4:0]  ID_RT,
    input  logic        ID_UsesRT,
    input  logic        ID_MulDiv,
    input  logic        EX_Valid,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Dest,
    output logic        STALL_IF,
    output logic        FLUSH_IFID,
    output logic        FLUSH_IDEX,
    output logic        MD_Busy,
    output logic [31:0] Stall_Count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               MD_MULTI = (MD_LATENCY > 1);

    state_t            state;
    logic [CNT_W-1:0]  md_cnt;
    logic [31:0]       stall_cnt;

    logic load_use;
    logic md_start;
    logic stall;
    logic flush_ifid;
    logic flush_idex;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. $0 is never a real dependency.
    assign load_use = EX_Valid && EX_MemRead && (EX_Dest != 5'd0) && ID_Valid &&
                      ((EX_Dest == ID_RS) || (ID_UsesRT && (EX_Dest == ID_RT)));

    // A mult/div only needs the wait state when it occupies EX for more
    // than one cycle.
    assign md_start = MD_MULTI && ID_Valid && ID_MulDiv;

    // Control outputs in priority order. All outputs are forced low while
    // reset is held so the latches see a quiet pipeline during reset.
    // IF_Ready is only looked at when not stalling, so a held instruction
    // is never flushed from IF/ID.
    always_comb begin
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!RESET) begin
            stall      = 1'b0;
        end else if (EXT_FLUSH) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (state == MD_WAIT) begin
            stall      = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            stall      = 1'b1;
            flush_idex = 1'b1;
        end else begin
            flush_ifid = !IF_Ready;
        end
    end

    assign STALL_IF    = stall;
    assign FLUSH_IFID  = flush_ifid;
    assign FLUSH_IDEX  = flush_idex;
    assign MD_Busy     = RESET && (state == MD_WAIT);
    assign Stall_Count = stall_cnt;

    // Controller state and mult/div countdown. The countdown holds the number
    // of wait cycles still to come; leaving MD_WAIT on the cycle it reads 1
    // lets the next ID instruction advance exactly MD_LATENCY edges after the
    // mult/div entered EX. A load-use stall keeps RUN so that a mult/div
    // waiting behind the load starts its wait only once it really advances.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= RUN;
            md_cnt <= '0;
        end else if (EXT_FLUSH) begin
            state  <= RUN;
            md_cnt <= '0;
        end else if (state == MD_WAIT) begin
            md_cnt <= md_cnt - CNT_ONE;
            if (md_cnt == CNT_ONE) begin
                state <= RUN;
            end
        end else if (load_use) begin
            state <= RUN;
        end else if (md_start) begin
            state  <= MD_WAIT;
            md_cnt <= MD_LOAD;
        end
    end

    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (MD_LATENCY=4). Each cycle the
// stimulus and the hand-derived expected outputs are given together; the
// expectation is pushed onto a scoreboard queue when the inputs are driven
// and popped and compared once the outputs have settled, before the edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic        stall;
        logic        fifid;
        logic        fidex;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        EXT_FLUSH;
    logic        IF_Ready;
    logic        ID_Valid;
    logic [4:0]  ID_RS;
    logic [4:0]  ID_RT;
    logic        ID_UsesRT;
    logic        ID_MulDiv;
    logic        EX_Valid;
    logic        EX_MemRead;
    logic [4:0]  EX_Dest;
    logic        STALL_IF;
    logic        FLUSH_IFID;
    logic        FLUSH_IDEX;
    logic        MD_Busy;
    logic [31:0] Stall_Count;

    exp_t scoreboard[$];
    int   checks_total;
    int   checks_passed;

    pipe_hazard_ctrl #(
        .MD_LATENCY(4),
        .CNT_W(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .EXT_FLUSH(EXT_FLUSH),
        .IF_Ready(IF_Ready),
        .ID_Valid(ID_Valid),
        .ID_RS(ID_RS),
        .ID_RT(ID_RT),
        .ID_UsesRT(ID_UsesRT),
        .ID_MulDiv(ID_MulDiv),
        .EX_Valid(EX_Valid),
        .EX_MemRead(EX_MemRead),
        .EX_Dest(EX_Dest),
        .STALL_IF(STALL_IF),
        .FLUSH_IFID(FLUSH_IFID),
        .FLUSH_IDEX(FLUSH_IDEX),
        .MD_Busy(MD_Busy),
        .Stall_Count(Stall_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] expected);
        checks_total++;
        if (got === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, push the expected
    // outputs, then pop and compare them before the next rising edge.
    task automatic applyStimulus(
        input string      tag,
        input logic       rstn,
        input logic       flush,
        input logic       ifr,
        input logic       idv,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       usesrt,
        input logic       muldiv,
        input logic       exv,
        input logic       exmr,
        input logic [4:0] exd,
        input logic       e_stall,
        input logic       e_fifid,
        input logic       e_fidex,
        input logic       e_busy,
        input logic [31:0] e_cnt
    );
        exp_t e;
        exp_t got_exp;
        @(negedge CLK);
        RESET      = rstn;
        EXT_FLUSH  = flush;
        IF_Ready   = ifr;
        ID_Valid   = idv;
        ID_RS      = rs;
        ID_RT      = rt;
        ID_UsesRT  = usesrt;
        ID_MulDiv  = muldiv;
        EX_Valid   = exv;
        EX_MemRead = exmr;
        EX_Dest    = exd;
        e.stall = e_stall;
        e.fifid = e_fifid;
        e.fidex = e_fidex;
        e.busy  = e_busy;
        e.cnt   = e_cnt;
        scoreboard.push_back(e);
        #2;
        if (scoreboard.size() == 0) begin
            checkOutput({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            got_exp = scoreboard.pop_front();
            checkOutput({tag, ".STALL_IF"},    {31'd0, STALL_IF},   {31'd0, got_exp.stall});
            checkOutput({tag, ".FLUSH_IFID"},  {31'd0, FLUSH_IFID}, {31'd0, got_exp.fifid});
            checkOutput({tag, ".FLUSH_IDEX"},  {31'd0, FLUSH_IDEX}, {31'd0, got_exp.fidex});
            checkOutput({tag, ".MD_Busy"},     {31'd0, MD_Busy},    {31'd0, got_exp.busy});
            checkOutput({tag, ".Stall_Count"}, Stall_Count,         got_exp.cnt);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        RESET      = 1'b0;
        EXT_FLUSH  = 1'b0;
        IF_Ready   = 1'b1;
        ID_Valid   = 1'b0;
        ID_RS      = 5'd0;
        ID_RT      = 5'd0;
        ID_UsesRT  = 1'b0;
        ID_MulDiv  = 1'b0;
        EX_Valid   = 1'b0;
        EX_MemRead = 1'b0;
        EX_Dest    = 5'd0;

        // Reset held: outputs quiet even with flush and a load-use pattern present.
        //            tag        rst fl  ifr idv rs    rt    urt md  exv exm exd    st fi fe bz cnt
        applyStimulus("rst_hold", 0, 1, 0, 1, 5'd5, 5'd0, 0, 0, 1, 1, 5'd5,  0, 0, 0, 0, 32'd0);
        applyStimulus("idle",     1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 32'd0);

        // Load-use on rs: exactly one stall, then the bubble in EX clears it.
        applyStimulus("lu_rs",    1, 0, 1, 1, 5'd5, 5'd0, 0, 0, 1, 1, 5'd5,  1, 0, 1, 0, 32'd0);
        applyStimulus("lu_after", 1, 0, 1, 1, 5'd5, 5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 32'd1);
        // Load into $0 is never a hazard.
        applyStimulus("lu_zero",  1, 0, 1, 1, 5'd0, 5'd0, 0, 0, 1, 1, 5'd0,  0, 0, 0, 0, 32'd1);
        // rt match only counts when the instruction reads rt.
        applyStimulus("lu_rt_no", 1, 0, 1, 1, 5'd3, 5'd7, 0, 0, 1, 1, 5'd7,  0, 0, 0, 0, 32'd1);
        applyStimulus("lu_rt",    1, 0, 1, 1, 5'd3, 5'd7, 1, 0, 1, 1, 5'd7,  1, 0, 1, 0, 32'd1);
        // Non-load in EX writing the same register: no stall.
        applyStimulus("no_load",  1, 0, 1, 1, 5'd3, 5'd7, 1, 0, 1, 0, 5'd7,  0, 0, 0, 0, 32'd2);

        // Mult/div: advances, then three stall cycles; IF_Ready=0 is ignored while stalled.
        applyStimulus("md_issue", 1, 0, 1, 1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0,  0, 0, 0, 0, 32'd2);
        applyStimulus("md_w1",    1, 0, 0, 1, 5'd4, 5'd0, 0, 0, 1, 0, 5'd9,  1, 0, 1, 1, 32'd2);
        applyStimulus("md_w2",    1, 0, 1, 1, 5'd4, 5'd0, 0, 0, 1, 0, 5'd9,  1, 0, 1, 1, 32'd3);
        applyStimulus("md_w3",    1, 0, 1, 1, 5'd4, 5'd0, 0, 0, 1, 0, 5'd9,  1, 0, 1, 1, 32'd4);
        applyStimulus("md_done",  1, 0, 1, 1, 5'd4, 5'd0, 0, 0, 1, 0, 5'd9,  0, 0, 0, 0, 32'd5);

        // Fetch miss in RUN for two cycles.
        applyStimulus("miss1",    1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 1, 0, 0, 32'd5);
        applyStimulus("miss2",    1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 1, 0, 0, 32'd5);

        // Mult/div issue together with a fetch miss, then flush in MD_WAIT with lu active.
        applyStimulus("md_miss",  1, 0, 0, 1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0,  0, 1, 0, 0, 32'd5);
        applyStimulus("fl_mdw",   1, 1, 1, 1, 5'd6, 5'd0, 0, 0, 1, 1, 5'd6,  0, 1, 1, 1, 32'd5);
        applyStimulus("fl_after", 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 32'd5);

        // Mult/div behind a load: lu first, wait state only after it advances;
        // reset arrives mid-wait with two wait cycles still to go.
        applyStimulus("mdlu_st",  1, 0, 1, 1, 5'd5, 5'd0, 0, 1, 1, 1, 5'd5,  1, 0, 1, 0, 32'd5);
        applyStimulus("mdlu_go",  1, 0, 1, 1, 5'd5, 5'd0, 0, 1, 0, 0, 5'd0,  0, 0, 0, 0, 32'd6);
        applyStimulus("mdlu_w1",  1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0,  1, 0, 1, 1, 32'd6);
        applyStimulus("rst_mdw",  0, 0, 1, 0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0,  0, 0, 0, 0, 32'd0);
        applyStimulus("rst_rel",  1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 32'd0);
        applyStimulus("rst_rel2", 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 32'd0);

        // Saturation: preload the counter just below its ceiling, then stall.
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        applyStimulus("sat1",     1, 0, 1, 1, 5'd5, 5'd0, 0, 0, 1, 1, 5'd5,  1, 0, 1, 0, 32'hFFFF_FFFE);
        applyStimulus("sat2",     1, 0, 1, 1, 5'd5, 5'd0, 0, 0, 1, 1, 5'd5,  1, 0, 1, 0, 32'hFFFF_FFFF);
        applyStimulus("sat3",     1, 0, 1, 1, 5'd5, 5'd0, 0, 0, 1, 1, 5'd5,  1, 0, 1, 0, 32'hFFFF_FFFF);
        applyStimulus("sat_hold", 1, 0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 32'hFFFF_FFFF);

        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit that sequences the stall and flush inputs of the IF/ID and ID/EX pipeline registers. It detects load-use hazards, holds the front end while a multi-cycle multiply/divide occupies EX, inserts bubbles on fetch misses, and applies external (exception) flushes. It sits beside the decode stage and drives the STALL/FLUSH pins of the inter-stage latches.

## Interface
- MD_LATENCY, 4: EX occupancy of mult/div in cycles; legal 1..15.
- CNT_W, 4: width of the mult/div countdown register.
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- EXT_FLUSH  in  1  exception/redirect flush request, valid this cycle
- IF_Ready  in  1  fetch stage presents a valid instruction this cycle
- ID_Valid  in  1  IF/ID register holds a real instruction
- ID_RS  in  5  source register rs of ID instruction
- ID_RT  in  5  source register rt of ID instruction
- ID_UsesRT  in  1  ID instruction reads rt
- ID_MulDiv  in  1  ID instruction is mult/multu/div/divu
- EX_Valid  in  1  ID/EX register holds a real instruction
- EX_MemRead  in  1  EX instruction is a load
- EX_Dest  in  5  destination register of EX instruction
- STALL_IF  out  1  hold PC and IF/ID register
- FLUSH_IFID  out  1  load bubble (zeros) into IF/ID
- FLUSH_IDEX  out  1  load bubble (zeros) into ID/EX
- MD_Busy  out  1  controller is in MD_WAIT
- Stall_Count  out  32  saturating count of cycles with STALL_IF=1

## Operation
- States: RUN, MD_WAIT. Registered: state, md_cnt[CNT_W-1:0], Stall_Count.
- STALL_IF, FLUSH_IFID, FLUSH_IDEX, MD_Busy are combinational from registered state and current inputs; the latches sample them at the same posedge.
- Load-use hazard lu = EX_Valid & EX_MemRead & EX_Dest!=0 & ID_Valid & (EX_Dest==ID_RS | (ID_UsesRT & EX_Dest==ID_RT)).
- Per-cycle priority, highest first:
  1. EXT_FLUSH=1: FLUSH_IFID=1, FLUSH_IDEX=1, STALL_IF=0; next state RUN, md_cnt←0 (aborts MD_WAIT).
  2. MD_WAIT: STALL_IF=1, FLUSH_IDEX=1, FLUSH_IFID=0; md_cnt←md_cnt-1; md_cnt==1 → next RUN.
  3. RUN & lu: STALL_IF=1, FLUSH_IDEX=1, FLUSH_IFID=0; state stays RUN (bubble in EX clears lu next cycle).
  4. RUN & ID_Valid & ID_MulDiv & MD_LATENCY>1: instruction advances (no stall); next MD_WAIT, md_cnt←MD_LATENCY-1.
  5. RUN & IF_Ready=0: FLUSH_IFID=1, others 0.
  6. Otherwise all control outputs 0.
- Rule 5 also applies on a rule-4 cycle (mult/div enters EX while IF/ID takes a bubble if IF_Ready=0).
- While STALL_IF=1, IF_Ready is ignored (held instruction preserved; FLUSH_IFID never asserted with STALL_IF).
- MD_LATENCY=1: MD_WAIT never entered; mult/div treated as single-cycle.
- Stall_Count increments on every clock edge where STALL_IF=1; holds at 32'hFFFFFFFF.
- MD_Busy = (state==MD_WAIT).

## Timing
- Reset (RESET low, asynchronous): state=RUN, md_cnt=0, Stall_Count=0; STALL_IF=0, FLUSH_IFID=0, FLUSH_IDEX=0, MD_Busy=0, all held while RESET low. First state update on first posedge after RESET rises.
- Load-use: exactly one stall cycle per hazard; the dependent instruction enters EX one cycle late with a bubble ahead of it.
- Mult/div: instruction enters EX at edge N; STALL_IF=1 during cycles N+1..N+MD_LATENCY-1 (MD_LATENCY-1 cycles); next ID instruction advances at edge N+MD_LATENCY.
- EXT_FLUSH during MD_WAIT: flush outputs that cycle, RUN next cycle, no further stall.
- Reset asserted mid-MD_WAIT: immediate return to RUN with all outputs 0; Stall_Count cleared.
- Mult/div in ID with lu active: lu wins; MD_WAIT entered on the following cycle when the instruction advances.

## Test plan
- Reset: drive RESET low mid-MD_WAIT, md_cnt=2 -> all outputs 0 asynchronously, Stall_Count=0, MD_Busy=0 after release.
- Load-use: EX lw $5, ID add rs=5 -> STALL_IF=1, FLUSH_IDEX=1 for exactly 1 cycle; EX_Dest=0 case -> no stall.
- Mult/div, MD_LATENCY=4: mult in ID at edge 0 -> MD_Busy=1, STALL_IF=1 for cycles 1-3, next instruction enters EX at edge 4; Stall_Count=3.
- Fetch miss: IF_Ready=0 for 2 cycles in RUN -> FLUSH_IFID=1 both cycles, STALL_IF=0; IF_Ready=0 during MD_WAIT -> FLUSH_IFID=0.
- Flush priority: EXT_FLUSH=1 with lu=1 and in MD_WAIT (md_cnt=3) -> FLUSH_IFID=FLUSH_IDEX=1, STALL_IF=0, RUN next cycle.
- Saturation: preload/force Stall_Count=32'hFFFFFFFE, 3 stall cycles -> Stall_Count=32'hFFFFFFFF and holds.
